inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
Instruction fetch front-end sitting directly upstream of the multicycle MIPS core; its ins_out drives the core's ins_in.
- Issues sequential word reads to a 1-cycle-latency synchronous instruction memory.
- Buffers returned words in a small FIFO.
- Hands instructions to the core with a valid/ready handshake, because the core consumes one instruction per multi-cycle sequence.
- Supports branch/jump redirect (flush) and a halt/drain mode.

Parameters:
DEPTH, 4, queue entries (power of two, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset or start
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  pulse; leave IDLE and begin fetching at RESET_PC
halt  input  1  level; stop issuing new reads while high
imem_rd_en  output  1  read strobe to instruction memory (combinational)
imem_addr  output  32  byte address of read; equals fetch_pc
imem_rdata  input  32  read data, valid the cycle after imem_rd_en
ins_out  output  32  instruction at queue head
ins_pc  output  32  byte address of ins_out
ins_valid  output  1  queue non-empty
ins_ready  input  1  core accepts head this cycle
redirect  input  1  flush and refetch from redirect_pc
redirect_pc  input  32  new fetch address (word aligned)
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, fetch_pc=RESET_PC, queue emptied, inflight=0, count=0.
  - ins_valid=0, ins_out=0, ins_pc=0, imem_rd_en=0.
  - rst has priority over every other input.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: no reads. start -> FETCH.
  - FETCH: halt -> DRAIN. redirect handled in place.
  - DRAIN: no new reads; the outstanding response is still accepted; the queue keeps serving the core. halt low -> FETCH. redirect in DRAIN flushes, loads fetch_pc, and stays in DRAIN.
- Read issue:
  - imem_rd_en = (state==FETCH) && !halt && !redirect && (count + inflight < DEPTH).
  - Each issued read advances fetch_pc by PC_STEP, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
- Response: inflight is the registered imem_rd_en. When inflight is 1, imem_rdata is pushed at the next edge with tag pc = address of that read. The credit rule guarantees a push never hits a full queue.
- Pop: the head is removed at the edge where ins_valid && ins_ready. Push and pop in the same cycle leave count unchanged.
- ins_out, ins_pc and ins_valid reflect registered queue state only; there is no combinational path from imem_rdata.
  - Minimum latency from imem_rd_en to ins_valid is 2 cycles (read in cycle N, data in N+1, ins_valid in N+2).
- Redirect (cycle R):
  - At the edge ending R: queue flushed, count=0, fetch_pc=redirect_pc.
  - A response arriving in R is discarded. Any pop requested in R is ignored; redirect wins.
  - First read at redirect_pc in R+1; ins_valid=0 in R+1 and R+2.
- ins_out/ins_pc hold their last value when ins_valid=0.
- With DEPTH=4 and ins_ready held high, sustained throughput is 1 instruction/cycle.

Optional Feature:
Macro PREFETCH_STATS_EN.
- Defined: adds output stall_cnt (16 bits).
  - Increments each cycle state==FETCH && ins_ready && !ins_valid.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, start at cycle 0, ins_ready=1, memory word = address: imem_addr 0,4,8,... on consecutive cycles; first ins_valid at cycle 2 with ins_out=0, ins_pc=0; then 4,8 each cycle.
- ins_ready=0 after start: exactly 4 reads issued (0,4,8,12); count=4; imem_rd_en low thereafter. Then one pop: next read at 16.
- Redirect to 32'h0000_0100 while count=3 and a read is inflight: count=0 next cycle; stale data not queued; next imem_addr=0x100; first ins_pc=0x100.
- halt high with count=2: no new reads, inflight word still queued (count=3); core drains to 0; halt low resumes at next sequential address.
- RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- rst mid-operation with count=3: next cycle count=0, ins_valid=0, state IDLE; no reads until start. With PREFETCH_STATS_EN defined, stall_cnt=2 after the initial fill.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential 1-cycle-latency imem reads buffered in a FIFO for the core.
// Optional stall counter output is enabled by defining PREFETCH_STATS_EN.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     halt,
  output logic                     imem_rd_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              ins_out,
  output logic [31:0]              ins_pc,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic            r_inflight;
  logic [31:0]     r_inflight_pc;
  logic [31:0]     r_q_ins [DEPTH];
  logic [31:0]     r_q_pc  [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_hold_ins;
  logic [31:0]     r_hold_pc;
  logic [CW:0]     w_occ;
  logic            w_push;
  logic            w_pop;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: if (halt)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (!halt) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit check counts the in-flight read so a response always finds a free slot.
  always_comb begin
    w_occ      = {1'b0, r_count} + (CW+1)'(r_inflight);
    imem_rd_en = (r_state == S_FETCH) && !halt && !redirect && (w_occ < (CW+1)'(DEPTH));
  end

  assign imem_addr = r_fetch_pc;
  assign count     = r_count;
  assign ins_valid = (r_count != '0);
  assign ins_out   = ins_valid ? r_q_ins[r_rd_ptr] : r_hold_ins;
  assign ins_pc    = ins_valid ? r_q_pc[r_rd_ptr]  : r_hold_pc;
  assign w_push    = r_inflight && !redirect;
  assign w_pop     = ins_valid && ins_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_hold_ins    <= '0;
      r_hold_pc     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_inflight    <= imem_rd_en;
      r_inflight_pc <= r_fetch_pc;
      r_hold_ins    <= ins_out;
      r_hold_pc     <= ins_pc;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (r_state == S_IDLE && start)
          r_fetch_pc <= RESET_PC;
        else if (imem_rd_en)
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: contents are only visible while ins_valid is high.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_ins[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]  <= r_inflight_pc;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_state == S_FETCH && ins_ready && !ins_valid && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed scenarios plus a randomized run against a queue model.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst, start, halt, ins_ready, redirect;
  logic [31:0] redirect_pc;

  logic        imem_rd_en, imem_rd_en2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] ins_out, ins_out2, ins_pc, ins_pc2;
  logic        ins_valid, ins_valid2;
  logic [2:0]  count, count2;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  logic [31:0] mem_xor = 32'h0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
`ifdef PREFETCH_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_rd_en(imem_rd_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .ins_out(ins_out2), .ins_pc(ins_pc2), .ins_valid(ins_valid2), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .count(count2)
`ifdef PREFETCH_STATS_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_xor;
  endfunction

  // Synchronous memories; garbage on idle cycles so discarded responses are distinguishable.
  always @(posedge clk) begin
    imem_rdata  <= imem_rd_en  ? mem_word(imem_addr)  : $urandom;
    imem_rdata2 <= imem_rd_en2 ? mem_word(imem_addr2) : $urandom;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; halt = 1'b0; ins_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; mem_xor = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; halt = 1'b0; ins_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0500;
    tick();
    rst = 1'b0; start = 1'b0; redirect = 1'b0;
    #1;
    n_checks++;
    if (imem_rd_en !== 1'b0 || ins_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd_en=%b valid=%b count=%0d, required 0 0 0", imem_rd_en, ins_valid, count);
    end
    n_checks++;
    if (ins_out !== 32'h0 || ins_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: ins_out=%h ins_pc=%h, required 0 0", ins_out, ins_pc);
    end
    tick();
    n_checks++;
    if (imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rd_en=%b, required 0", imem_rd_en);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: rd_en=%b addr=%h, required 1 00000000", imem_rd_en, imem_addr);
    end
  endtask

  task automatic test_fill;
    do_reset();
    ins_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 32'(4*k)) begin
        n_fail++;
        $display("FAIL fill_addr k=%0d: rd_en=%b addr=%h, required 1 %h", k, imem_rd_en, imem_addr, 32'(4*k));
      end
      n_checks++;
      if (k < 2) begin
        if (ins_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_latency k=%0d: valid=%b, required 0", k, ins_valid);
        end
      end else if (ins_valid !== 1'b1 || ins_pc !== 32'(4*(k-2)) || ins_out !== 32'(4*(k-2)) || count !== 3'd1) begin
        n_fail++;
        $display("FAIL fill_head k=%0d: valid=%b pc=%h ins=%h count=%0d, required 1 %h %h 1",
                 k, ins_valid, ins_pc, ins_out, count, 32'(4*(k-2)), 32'(4*(k-2)));
      end
`ifdef PREFETCH_STATS_EN
      if (k == 2) begin
        n_checks++;
        if (stall_cnt !== 16'd2) begin
          n_fail++;
          $display("FAIL stall_cnt: got %0d, required 2", stall_cnt);
        end
      end
`endif
      tick();
    end
    ins_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int exp_cnt;
      exp_cnt = (k < 1) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
      #1;
      n_checks++;
      if (imem_rd_en !== (k < 4) || (k < 4 && imem_addr !== 32'(4*k)) || count !== 3'(exp_cnt)) begin
        n_fail++;
        $display("FAIL bp_credit k=%0d: rd_en=%b addr=%h count=%0d, required %b %h %0d",
                 k, imem_rd_en, imem_addr, count, (k < 4), 32'(4*k), exp_cnt);
      end
      tick();
    end
    ins_ready = 1'b1;
    #1;
    n_checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pop: valid=%b pc=%h rd_en=%b, required 1 0 0", ins_valid, ins_pc, imem_rd_en);
    end
    tick();
    ins_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd3 || imem_rd_en !== 1'b1 || imem_addr !== 32'd16 || ins_pc !== 32'd4) begin
      n_fail++;
      $display("FAIL bp_resume: count=%0d rd_en=%b addr=%h head=%h, required 3 1 10 4", count, imem_rd_en, imem_addr, ins_pc);
    end
  endtask

  task automatic test_redirect;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    // count=3 with the read of address 12 in flight
    redirect = 1'b1; redirect_pc = 32'h0000_0100; ins_ready = 1'b1;
    #1;
    n_checks++;
    if (count !== 3'd3 || imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_cycle: count=%0d rd_en=%b, required 3 0", count, imem_rd_en);
    end
    tick();
    redirect = 1'b0; ins_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || ins_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_r1: count=%0d valid=%b rd_en=%b addr=%h, required 0 0 1 100", count, ins_valid, imem_rd_en, imem_addr);
    end
    tick();
    #1;
    n_checks++;
    if (ins_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_r2: valid=%b count=%0d addr=%h, required 0 0 104", ins_valid, count, imem_addr);
    end
    tick();
    #1;
    n_checks++;
    if (ins_valid !== 1'b1 || count !== 3'd1 || ins_pc !== 32'h100 || ins_out !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_head: valid=%b count=%0d pc=%h ins=%h, required 1 1 100 100", ins_valid, count, ins_pc, ins_out);
    end
  endtask

  task automatic test_halt;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    halt = 1'b1;
    #1;
    n_checks++;
    if (count !== 3'd2 || imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_stop: count=%0d rd_en=%b, required 2 0", count, imem_rd_en);
    end
    tick();
    ins_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (count !== 3'(3 - k) || ins_pc !== 32'(4*k) || imem_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_drain k=%0d: count=%0d pc=%h rd_en=%b, required %0d %h 0", k, count, ins_pc, imem_rd_en, 3 - k, 32'(4*k));
      end
      tick();
    end
    halt = 1'b0;
    #1;
    n_checks++;
    if (ins_valid !== 1'b0 || ins_pc !== 32'd8 || ins_out !== 32'd8 || imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_hold: valid=%b pc=%h ins=%h rd_en=%b, required 0 8 8 0", ins_valid, ins_pc, ins_out, imem_rd_en);
    end
    tick();
    #1;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 32'd12) begin
      n_fail++;
      $display("FAIL halt_resume: rd_en=%b addr=%h, required 1 c", imem_rd_en, imem_addr);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    ins_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ea, ep;
      ea = 32'hFFFF_FFF8 + 32'(4*k);
      ep = 32'hFFFF_FFF8 + 32'(4*(k-2));
      #1;
      n_checks++;
      if (imem_rd_en2 !== 1'b1 || imem_addr2 !== ea || (k >= 2 && (ins_pc2 !== ep || ins_out2 !== ep))) begin
        n_fail++;
        $display("FAIL wrap k=%0d: addr=%h pc=%h ins=%h, required %h %h %h", k, imem_addr2, ins_pc2, ins_out2, ea, ep, ep);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (count !== 3'd0 || ins_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid k=%0d: count=%0d valid=%b rd_en=%b, required 0 0 0", k, count, ins_valid, imem_rd_en);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_restart: rd_en=%b addr=%h, required 1 0", imem_rd_en, imem_addr);
    end
  endtask

  // Transaction-level model: a queue of fetched PCs, one pending read, and a mode.
  task automatic test_random;
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_inf_pc, m_hold_ins, m_hold_pc, e_ins, e_pc;
    logic        m_inf, e_rd, e_valid;
    int          m_mode;  // 0 idle, 1 fetching, 2 draining
    int          errs;
    do_reset();
    mem_xor = 32'h1357_9BDF;
    m_pc = 32'h0; m_inf = 1'b0; m_inf_pc = 32'h0; m_hold_ins = 32'h0; m_hold_pc = 32'h0; m_mode = 0;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      start       = ($urandom_range(0, 9) == 0);
      halt        = ($urandom_range(0, 6) == 0);
      ins_ready   = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      #1;
      e_rd    = (m_mode == 1) && !halt && !redirect && (m_q.size() + int'(m_inf) < 4);
      e_valid = (m_q.size() != 0);
      e_pc    = e_valid ? m_q[0] : m_hold_pc;
      e_ins   = e_valid ? mem_word(m_q[0]) : m_hold_ins;
      n_checks++;
      if (imem_rd_en !== e_rd || (e_rd && imem_addr !== m_pc) || ins_valid !== e_valid ||
          count !== 3'(m_q.size()) || ins_pc !== e_pc || ins_out !== e_ins) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random c=%0d: rd=%b addr=%h v=%b cnt=%0d pc=%h ins=%h, required %b %h %b %0d %h %h",
                   c, imem_rd_en, imem_addr, ins_valid, count, ins_pc, ins_out,
                   e_rd, m_pc, e_valid, m_q.size(), e_pc, e_ins);
        errs++;
      end
      m_hold_pc = e_pc; m_hold_ins = e_ins;
      if (redirect) begin
        m_q.delete();
        m_pc = redirect_pc;
      end else begin
        if (e_valid && ins_ready) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_inf_pc);
        if (m_mode == 0 && start) m_pc = 32'h0;
      end
      m_inf = e_rd; m_inf_pc = m_pc;
      if (e_rd) m_pc = m_pc + 32'd4;
      if (m_mode == 0 && start) m_mode = 1;
      else if (m_mode == 1 && halt) m_mode = 2;
      else if (m_mode == 2 && !halt) m_mode = 1;
      tick();
    end
    start = 1'b0; halt = 1'b0; redirect = 1'b0; ins_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; ins_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_fill();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
